blink_meter: RTL and testbench

Measures the blink period and high time of an external 1-bit square wave in milliseconds. It is the receiving counterpart of the board's LED blinker: a pin driven by a blinker, for example through a GPIO loopback, is sampled on the 50 MHz clock. A result with a one-cycle valid strobe is published on each rising edge after a complete period. The result feeds the board's 7-segment or LED display logic.

---
 rtl/blink_meter_if.sv | 20 ++
 rtl/blink_meter.sv | 108 ++++++++++
 tb/tb_blink_meter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/blink_meter_if.sv
// Measurement bus between a square-wave source and the blink meter.
// The slave side samples sig_in and publishes period/high-time results.
interface blink_meter_if;
  logic        sig_in;
  logic [13:0] period_ms;
  logic [13:0] high_ms;
  logic        valid;
  logic        timeout;
  logic        measuring;

  modport master (
    output sig_in,
    input  period_ms, high_ms, valid, timeout, measuring
  );

  modport slave (
    input  sig_in,
    output period_ms, high_ms, valid, timeout, measuring
  );
endinterface

// File: rtl/blink_meter.sv
// Measures rising-to-rising period and rising-to-falling high time of sig_in in ms.
// Results publish 2 edges after the first sampling edge of a rise; no backpressure, valid is a 1-cycle strobe.
module blink_meter #(
  parameter int unsigned TICKS_PER_MS = 50000,
  parameter int unsigned MAX_MS       = 16383
) (
  input  logic          clk,
  input  logic          rst,
  blink_meter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [15:0] PRE_LAST = 16'(TICKS_PER_MS - 1);
  localparam logic [13:0] MS_LAST  = 14'(MAX_MS - 1);

  state_t      state_q;
  logic        s1_q, s2_q, s3_q;
  logic [15:0] pre_q, pre_d;
  logic [13:0] ms_cnt_q, ms_cnt_d;
  logic [13:0] high_cnt_q;
  logic [13:0] period_q, high_q;
  logic        valid_q, timeout_q, measuring_q;

  logic rise, fall, ms_tick, tout_hit;

  assign rise     = s2_q & ~s3_q;
  assign fall     = ~s2_q & s3_q;
  assign ms_tick  = (pre_q == PRE_LAST);
  assign tout_hit = ms_tick && (ms_cnt_q == MS_LAST);

  // Events coinciding with a tick see the post-tick count, so an exact
  // N-ms interval reads as N rather than N-1.
  assign pre_d    = ms_tick ? 16'd0 : pre_q + 16'd1;
  assign ms_cnt_d = ms_tick ? ms_cnt_q + 14'd1 : ms_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      pre_q       <= '0;
      ms_cnt_q    <= '0;
      high_cnt_q  <= '0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      measuring_q <= 1'b0;
    end else begin
      s1_q     <= bus.sig_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      valid_q  <= 1'b0;
      pre_q    <= pre_d;
      ms_cnt_q <= ms_cnt_d;

      case (state_q)
        IDLE: begin
          pre_q    <= '0;
          ms_cnt_q <= '0;
          if (rise) begin
            state_q     <= HIGH;
            measuring_q <= 1'b1;
          end
        end
        HIGH: begin
          // A fall on the timeout tick loses: the measurement is abandoned.
          if (tout_hit) begin
            state_q     <= IDLE;
            measuring_q <= 1'b0;
            timeout_q   <= 1'b1;
          end else if (fall) begin
            high_cnt_q <= ms_cnt_d;
            state_q    <= LOW;
          end
        end
        LOW: begin
          if (rise) begin
            period_q  <= ms_cnt_d;
            high_q    <= high_cnt_q;
            valid_q   <= 1'b1;
            timeout_q <= 1'b0;
            pre_q     <= '0;
            ms_cnt_q  <= '0;
            state_q   <= HIGH;
          end else if (tout_hit) begin
            state_q     <= IDLE;
            measuring_q <= 1'b0;
            timeout_q   <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          measuring_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.period_ms = period_q;
  assign bus.high_ms   = high_q;
  assign bus.valid     = valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.measuring = measuring_q;

endmodule

// File: tb/tb_blink_meter.sv
// Bench for blink_meter: timestamp-based reference model compared every cycle,
// with directed scenarios followed by randomized high/low segments.
module tb_blink_meter;
  localparam int T   = 10;
  localparam int MAX = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  blink_meter_if bus ();

  blink_meter #(.TICKS_PER_MS(T), .MAX_MS(MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: a sig_in change driven after edge k is first sampled at
  // k+1 and acted upon at edge k+3. Results derive from edge timestamps.
  typedef struct {
    int t;
    bit lvl;
  } ev_t;

  ev_t  evq[$];
  int   ecnt    = 0;
  int   m_mode  = 0;   // 0 idle, 1 high phase, 2 low phase
  int   m_trise = 0;
  int   m_tfall = 0;
  logic        e_valid = 1'b0;
  logic        e_tout  = 1'b0;
  logic [13:0] e_per   = '0;
  logic [13:0] e_high  = '0;

  task automatic model_step();
    bit rise_now, fall_now;
    ecnt++;
    if (rst) begin
      m_mode  = 0;
      e_valid = 1'b0;
      e_tout  = 1'b0;
      e_per   = '0;
      e_high  = '0;
      evq.delete();
      return;
    end
    e_valid  = 1'b0;
    rise_now = 1'b0;
    fall_now = 1'b0;
    if (evq.size() > 0 && evq[0].t == ecnt) begin
      rise_now = evq[0].lvl;
      fall_now = !evq[0].lvl;
      void'(evq.pop_front());
    end
    if (m_mode != 0 && ecnt == m_trise + MAX * T && !(rise_now && m_mode == 2)) begin
      e_tout = 1'b1;
      m_mode = 0;
    end else if (rise_now) begin
      if (m_mode == 2) begin
        e_per   = 14'((ecnt - m_trise) / T);
        e_high  = 14'((m_tfall - m_trise) / T);
        e_valid = 1'b1;
        e_tout  = 1'b0;
      end
      m_mode  = 1;
      m_trise = ecnt;
    end else if (fall_now && m_mode == 1) begin
      m_mode  = 2;
      m_tfall = ecnt;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (!rst)
      chk("cycle", {1'b0, bus.valid, bus.timeout, bus.measuring, bus.period_ms, bus.high_ms},
          {1'b0, e_valid, e_tout, (m_mode != 0), e_per, e_high});
  end

  task automatic hold(input bit lvl, input int n);
    ev_t e;
    @(posedge clk);
    #1;
    if (bus.sig_in != lvl) begin
      bus.sig_in = lvl;
      e.t   = ecnt + 3;
      e.lvl = lvl;
      evq.push_back(e);
    end
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"},  {31'd0, bus.valid},     32'd0);
    chk({tag, "_tout"},   {31'd0, bus.timeout},   32'd0);
    chk({tag, "_meas"},   {31'd0, bus.measuring}, 32'd0);
    chk({tag, "_period"}, {18'd0, bus.period_ms}, 32'd0);
    chk({tag, "_high"},   {18'd0, bus.high_ms},   32'd0);
  endtask

  initial begin
    int dur;
    bit lvl;
    bus.sig_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Square wave 30/70: first rise only arms, then 10 ms / 3 ms.
    repeat (4) begin
      hold(1'b1, 30);
      hold(1'b0, 70);
    end
    // Non-multiple periods and sub-millisecond result.
    hold(1'b1, 25); hold(1'b0, 14);
    hold(1'b1, 4);  hold(1'b0, 4);
    hold(1'b1, 4);  hold(1'b0, 20);
    // Stuck high, then re-arm and publish.
    hold(1'b1, 100); hold(1'b0, 20);
    hold(1'b1, 30);  hold(1'b0, 40);
    // Rise exactly on the timeout tick wins; one cycle later it times out.
    hold(1'b1, 30);  hold(1'b0, 50);
    hold(1'b1, 30);  hold(1'b0, 51);
    hold(1'b1, 30);  hold(1'b0, 30);
    // Fall exactly on the timeout tick loses.
    hold(1'b1, 80);  hold(1'b0, 20);
    hold(1'b1, 20);  hold(1'b0, 20);
    hold(1'b1, 20);  hold(1'b0, 20);

    // Asynchronous reset in the middle of the low phase.
    hold(1'b1, 30);  hold(1'b0, 20);
    #3;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hold(1'b0, 5);
    hold(1'b1, 30); hold(1'b0, 30);
    hold(1'b1, 30); hold(1'b0, 30);

    // Randomized segments, occasionally long enough to time out.
    lvl = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(7) == 0) dur = $urandom_range(100, 70);
      else dur = $urandom_range(60, 2);
      hold(lvl, dur);
      lvl = !lvl;
    end
    hold(1'b0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
